// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - two-master request/completion and single-slave bus bundle for bus_arbiter
interface bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   logic              m0_req;
   logic              m0_we;
   logic [2:0]        m0_op;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_rdy;
   logic [DATA_W-1:0] m0_rdata;

   logic              m1_req;
   logic              m1_we;
   logic [2:0]        m1_op;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_rdy;
   logic [DATA_W-1:0] m1_rdata;

   logic              s_cs;
   logic              s_rd;
   logic              s_wr;
   logic [2:0]        s_op;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_wdata;
   logic              s_ack;
   logic [DATA_W-1:0] s_rdata;

   logic              err;
   logic              gnt;

   // arbiter view: takes master requests and slave responses, drives completions and the slave bus
   modport master (
      input  m0_req, m0_we, m0_op, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_op, m1_addr, m1_wdata,
      input  s_ack, s_rdata,
      output m0_rdy, m0_rdata, m1_rdy, m1_rdata,
      output s_cs, s_rd, s_wr, s_op, s_addr, s_wdata,
      output err, gnt
   );

   // environment view: requesting masters plus the peripheral slave
   modport slave (
      output m0_req, m0_we, m0_op, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_op, m1_addr, m1_wdata,
      output s_ack, s_rdata,
      input  m0_rdy, m0_rdata, m1_rdy, m1_rdata,
      input  s_cs, s_rd, s_wr, s_op, s_addr, s_wdata,
      input  err, gnt
   );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin two-master arbiter with issue/wait/done sequencing and timeout
module bus_arbiter #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                TIMEOUT  = 15,
   parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
   input logic           clk,
   input logic           rst,
   bus_arbiter_if.master bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // counter is at least 4 bits; wider only when TIMEOUT needs it
   localparam int               CNT_W    = (TIMEOUT > 15) ? $clog2(TIMEOUT + 1) : 4;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   logic [1:0]        state;
   logic              last_gnt;
   logic              gnt_q;
   logic              we_q;
   logic [CNT_W-1:0]  cnt;

   logic              s_cs_q;
   logic              s_rd_q;
   logic              s_wr_q;
   logic [2:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic              m0_rdy_q;
   logic              m1_rdy_q;
   logic [DATA_W-1:0] m0_rdata_q;
   logic [DATA_W-1:0] m1_rdata_q;
   logic              err_q;

   logic              pick_m1;
   logic              sel_we;
   logic [2:0]        sel_op;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              expired;
   logic [DATA_W-1:0] result;

   // winner selection, timeout detect and completion data
   always_comb begin
      // on a tie the master that was not granted last wins
      pick_m1   = bus.m1_req & (~bus.m0_req | ~last_gnt);
      sel_we    = pick_m1 ? bus.m1_we    : bus.m0_we;
      sel_op    = pick_m1 ? bus.m1_op    : bus.m0_op;
      sel_addr  = pick_m1 ? bus.m1_addr  : bus.m0_addr;
      sel_wdata = pick_m1 ? bus.m1_wdata : bus.m0_wdata;
      expired   = (TIMEOUT != 0) && (cnt == CNT_LAST);
      // ack beats expiry in the same cycle; writes complete with zero data
      if (bus.s_ack) begin
         result = we_q ? '0 : bus.s_rdata;
      end else begin
         result = ERR_DATA;
      end
   end

   // transaction sequencer; every bus and completion output is a flop
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         last_gnt   <= 1'b1;
         gnt_q      <= 1'b0;
         we_q       <= 1'b0;
         cnt        <= '0;
         s_cs_q     <= 1'b0;
         s_rd_q     <= 1'b0;
         s_wr_q     <= 1'b0;
         op_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         m0_rdy_q   <= 1'b0;
         m1_rdy_q   <= 1'b0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
         err_q      <= 1'b0;
      end else begin
         // strobes and completion signals are single-cycle pulses
         s_rd_q     <= 1'b0;
         s_wr_q     <= 1'b0;
         m0_rdy_q   <= 1'b0;
         m1_rdy_q   <= 1'b0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
         err_q      <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.m0_req | bus.m1_req) begin
                  gnt_q   <= pick_m1;
                  we_q    <= sel_we;
                  op_q    <= sel_op;
                  addr_q  <= sel_addr;
                  wdata_q <= sel_wdata;
                  s_cs_q  <= 1'b1;
                  s_rd_q  <= ~sel_we;
                  s_wr_q  <= sel_we;
                  cnt     <= '0;
                  state   <= ST_ISSUE;
               end
            end
            ST_ISSUE, ST_WAIT: begin
               if (bus.s_ack || expired) begin
                  s_cs_q   <= 1'b0;
                  m0_rdy_q <= ~gnt_q;
                  m1_rdy_q <= gnt_q;
                  err_q    <= ~bus.s_ack;
                  if (gnt_q) begin
                     m1_rdata_q <= result;
                  end else begin
                     m0_rdata_q <= result;
                  end
                  state <= ST_DONE;
               end else begin
                  cnt   <= cnt + 1'b1;
                  state <= ST_WAIT;
               end
            end
            ST_DONE: begin
               last_gnt <= gnt_q;
               state    <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.s_cs     = s_cs_q;
   assign bus.s_rd     = s_rd_q;
   assign bus.s_wr     = s_wr_q;
   assign bus.s_op     = op_q;
   assign bus.s_addr   = addr_q;
   assign bus.s_wdata  = wdata_q;
   assign bus.m0_rdy   = m0_rdy_q;
   assign bus.m1_rdy   = m1_rdy_q;
   assign bus.m0_rdata = m0_rdata_q;
   assign bus.m1_rdata = m1_rdata_q;
   assign bus.err      = err_q;
   assign bus.gnt      = gnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - vector table and corner sequences for bus_arbiter
module tb_bus_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   bus_arbiter #(
      .ADDR_W(32), .DATA_W(32), .TIMEOUT(15), .ERR_DATA(32'hDEADBEEF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int nchk  = 0;
   int nfail = 0;

   typedef struct {
      string       name;
      logic        r0, r1, we0, we1, drop;
      logic [2:0]  op0, op1;
      logic [31:0] a0, a1, d0, d1;
      int          ack_dly;
      logic [31:0] srd;
      logic        e_gnt;
      logic [31:0] e_rdata;
      logic        e_err;
      int          e_lat;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string n, input logic r0, input logic r1,
                               input logic we0, input logic we1,
                               input logic [2:0] op0, input logic [2:0] op1,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic drop, input int ack_dly, input logic [31:0] srd,
                               input logic e_gnt, input logic [31:0] e_rdata,
                               input logic e_err, input int e_lat);
      vec_t v;
      v.name = n; v.r0 = r0; v.r1 = r1; v.we0 = we0; v.we1 = we1;
      v.op0 = op0; v.op1 = op1; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
      v.drop = drop; v.ack_dly = ack_dly; v.srd = srd;
      v.e_gnt = e_gnt; v.e_rdata = e_rdata; v.e_err = e_err; v.e_lat = e_lat;
      return v;
   endfunction

   task automatic idle_inputs();
      bus.m0_req = 0; bus.m0_we = 0; bus.m0_op = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
      bus.m1_req = 0; bus.m1_we = 0; bus.m1_op = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
      bus.s_ack = 0; bus.s_rdata = 0;
   endtask

   task automatic run_vec(input vec_t v);
      logic        e_we;
      logic [2:0]  e_op;
      logic [31:0] e_addr, e_wdata;
      int          lat, k;
      bit          done;
      e_we    = v.e_gnt ? v.we1 : v.we0;
      e_op    = v.e_gnt ? v.op1 : v.op0;
      e_addr  = v.e_gnt ? v.a1  : v.a0;
      e_wdata = v.e_gnt ? v.d1  : v.d0;
      @(negedge clk);
      bus.m0_req = v.r0; bus.m0_we = v.we0; bus.m0_op = v.op0; bus.m0_addr = v.a0; bus.m0_wdata = v.d0;
      bus.m1_req = v.r1; bus.m1_we = v.we1; bus.m1_op = v.op1; bus.m1_addr = v.a1; bus.m1_wdata = v.d1;
      bus.s_ack = 0;
      lat = 0; k = -1; done = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
         if (bus.m0_rdy || bus.m1_rdy) begin
            done = 1;
            chk({v.name, ".lat"}, lat, v.e_lat);
            chk({v.name, ".gnt"}, bus.gnt, v.e_gnt);
            chk({v.name, ".m0_rdy"}, bus.m0_rdy, !v.e_gnt);
            chk({v.name, ".m1_rdy"}, bus.m1_rdy, v.e_gnt);
            chk({v.name, ".m0_rdata"}, bus.m0_rdata, v.e_gnt ? 32'h0 : v.e_rdata);
            chk({v.name, ".m1_rdata"}, bus.m1_rdata, v.e_gnt ? v.e_rdata : 32'h0);
            chk({v.name, ".err"}, bus.err, v.e_err);
            chk({v.name, ".s_cs_done"}, bus.s_cs, 0);
            bus.m0_req = 0; bus.m1_req = 0; bus.s_ack = 0;
         end else if (bus.s_cs) begin
            k++;
            if (k == 0) begin
               chk({v.name, ".s_rd_issue"}, bus.s_rd, !e_we);
               chk({v.name, ".s_wr_issue"}, bus.s_wr, e_we);
            end else begin
               chk({v.name, ".strobe_wait"}, bus.s_rd | bus.s_wr, 0);
            end
            chk({v.name, ".s_addr"}, bus.s_addr, e_addr);
            chk({v.name, ".s_wdata"}, bus.s_wdata, e_wdata);
            chk({v.name, ".s_op"}, bus.s_op, e_op);
            if (v.drop && k == 0) begin
               bus.m0_req = 0; bus.m1_req = 0;
               bus.m0_addr = 32'hBAD0BAD0; bus.m1_addr = 32'hBAD1BAD1;
               bus.m0_wdata = 32'h0; bus.m1_wdata = 32'h0;
            end
            bus.s_ack   = (k == v.ack_dly);
            bus.s_rdata = bus.s_ack ? v.srd : (32'h5A5A0000 + k);
         end else begin
            bus.s_ack = 0;
         end
      end
      if (!done) begin
         nchk++;
         nfail++;
         $display("FAIL %s.rdy: got no completion in 40 cycles, expected rdy at cycle %0d", v.name, v.e_lat);
         bus.m0_req = 0; bus.m1_req = 0; bus.s_ack = 0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int got, quiet;
      logic exp_g;

      vq.push_back(mk("m0_rd_imm",     1,0, 0,0, 3'd2,3'd0, 32'h10,32'h0, 32'h0,32'h0, 0, 0, 32'h12345678, 0, 32'h12345678, 0, 2));
      vq.push_back(mk("m1_wr_wait3",   0,1, 0,1, 3'd0,3'd1, 32'h0,32'h20, 32'h0,32'hA5, 0, 3, 32'hFFFF0000, 1, 32'h0, 0, 5));
      vq.push_back(mk("both_m0",       1,1, 0,0, 3'd4,3'd3, 32'h30,32'h40, 32'h0,32'h0, 0, 1, 32'h0BADF00D, 0, 32'h0BADF00D, 0, 3));
      vq.push_back(mk("both_m1",       1,1, 0,0, 3'd4,3'd3, 32'h34,32'h44, 32'h0,32'h0, 0, 0, 32'hCAFE0001, 1, 32'hCAFE0001, 0, 2));
      vq.push_back(mk("m0_timeout",    1,0, 0,0, 3'd0,3'd0, 32'h80,32'h0, 32'h0,32'h0, 0, 99, 32'h0, 0, 32'hDEADBEEF, 1, 16));
      vq.push_back(mk("m1_ack_expiry", 0,1, 0,0, 3'd0,3'd6, 32'h0,32'h84, 32'h0,32'h0, 0, 14, 32'h55AA55AA, 1, 32'h55AA55AA, 0, 16));
      vq.push_back(mk("m0_wr_drop",    1,0, 1,0, 3'd5,3'd0, 32'h90,32'h0, 32'h77,32'h0, 1, 2, 32'h99999999, 0, 32'h0, 0, 4));
      vq.push_back(mk("m1_ack_late",   0,1, 0,0, 3'd0,3'd7, 32'h0,32'h94, 32'h0,32'h0, 0, 13, 32'h00000001, 1, 32'h00000001, 0, 15));
      vq.push_back(mk("both_m0_wr",    1,1, 1,0, 3'd5,3'd1, 32'hFFFFFFFC,32'h98, 32'hFFFFFFFF,32'h0, 0, 0, 32'h12121212, 0, 32'h0, 0, 2));

      rst = 1;
      idle_inputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.s_cs", bus.s_cs, 0);
      chk("rst.s_rd", bus.s_rd, 0);
      chk("rst.s_wr", bus.s_wr, 0);
      chk("rst.m0_rdy", bus.m0_rdy, 0);
      chk("rst.m1_rdy", bus.m1_rdy, 0);
      chk("rst.err", bus.err, 0);
      chk("rst.gnt", bus.gnt, 0);
      chk("rst.s_addr", bus.s_addr, 0);
      chk("rst.m0_rdata", bus.m0_rdata, 0);
      rst = 0;

      // stray ack in IDLE must not produce a completion
      bus.s_ack = 1; bus.s_rdata = 32'hFEEDFACE;
      quiet = 0;
      repeat (3) begin
         @(negedge clk);
         quiet += int'(bus.m0_rdy) + int'(bus.m1_rdy) + int'(bus.s_cs);
      end
      chk("idle_ack.ignored", quiet, 0);
      bus.s_ack = 0;

      for (int i = 0; i < vq.size(); i++) begin
         run_vec(vq[i]);
      end

      // reset while waiting abandons the transaction
      @(negedge clk);
      bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h50; bus.s_ack = 0;
      repeat (3) @(negedge clk);
      chk("rstwait.s_cs_before", bus.s_cs, 1);
      rst = 1; bus.m0_req = 0;
      @(negedge clk);
      chk("rstwait.s_cs", bus.s_cs, 0);
      chk("rstwait.s_rd", bus.s_rd, 0);
      chk("rstwait.m0_rdy", bus.m0_rdy, 0);
      chk("rstwait.m1_rdy", bus.m1_rdy, 0);
      rst = 0;
      quiet = 0;
      repeat (4) begin
         @(negedge clk);
         quiet += int'(bus.m0_rdy) + int'(bus.m1_rdy) + int'(bus.s_cs);
      end
      chk("rstwait.quiet", quiet, 0);

      // both held continuously: m0 first after reset, then alternate
      bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h60;
      bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h70;
      got = 0; exp_g = 0;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
         @(negedge clk);
         if (bus.m0_rdy || bus.m1_rdy) begin
            chk($sformatf("rr%0d.gnt", got), bus.gnt, exp_g);
            chk($sformatf("rr%0d.m0_rdy", got), bus.m0_rdy, !exp_g);
            chk($sformatf("rr%0d.m1_rdy", got), bus.m1_rdy, exp_g);
            chk($sformatf("rr%0d.rdata", got), exp_g ? bus.m1_rdata : bus.m0_rdata, 32'h100 + got);
            got++;
            exp_g = ~exp_g;
            bus.s_ack = 0;
         end else if (bus.s_cs) begin
            chk($sformatf("rr%0d.s_addr", got), bus.s_addr, exp_g ? 32'h70 : 32'h60);
            bus.s_ack = 1;
            bus.s_rdata = 32'h100 + got;
         end else begin
            bus.s_ack = 0;
         end
      end
      chk("rr.count", got, 4);
      idle_inputs();
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Two-master, single-slave arbiter that shares the peripheral/data-memory bus between the CPU data port (m0) and a secondary master (m1, boot loader or DMA). It sequences each access as an issue/wait/complete transaction with round-robin grant, a one-cycle command strobe, a slave acknowledge, and a timeout. It sits between the CPU load/store path and the peripheral block.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 15, max cycles in ISSUE+WAIT before forced completion; 0 disables timeout
ERR_DATA, 32'hDEADBEEF, rdata returned on timeout

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
m0_req  in  1  CPU request, held until m0_rdy
m0_we  in  1  1=write, 0=read
m0_op  in  3  access size/sign code, passed through to s_op
m0_addr  in  ADDR_W  address
m0_wdata  in  DATA_W  write data
m0_rdy  out  1  one-cycle completion pulse
m0_rdata  out  DATA_W  read data, valid while m0_rdy=1
m1_req, m1_we, m1_op, m1_addr, m1_wdata  in  same as m0  secondary master request
m1_rdy, m1_rdata  out  same as m0  secondary master completion
s_cs  out  1  slave select, high in ISSUE and WAIT
s_rd  out  1  read strobe, high only in ISSUE for reads
s_wr  out  1  write strobe, high only in ISSUE for writes
s_op  out  3  latched op
s_addr  out  ADDR_W  latched address
s_wdata  out  DATA_W  latched write data
s_ack  in  1  slave done; s_rdata valid in same cycle
s_rdata  in  DATA_W  slave read data
err  out  1  one-cycle pulse with rdy when a transaction timed out
gnt  out  1  current/last granted master (0=m0, 1=m1)

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. Reset: state=IDLE, all outputs 0, last-grant pointer=1, so m0 wins the first tie.
- IDLE: if any req, pick winner. Only one requests -> it wins. Both request -> the master not granted last wins. Latch we/op/addr/wdata of the winner, set gnt, go ISSUE. No req -> stay.
- ISSUE (exactly one cycle): s_cs=1, s_rd or s_wr=1. If s_ack=1, capture s_rdata and go DONE; else go WAIT.
- WAIT: s_cs=1, s_rd=s_wr=0, s_addr/s_wdata/s_op held stable. s_ack=1 -> capture s_rdata, go DONE.
- Timeout: 4-bit-or-wider counter cleared on entry to ISSUE, incremented each ISSUE/WAIT cycle without ack. When count==TIMEOUT-1 and no ack -> go DONE, rdata=ERR_DATA, err=1 in DONE. Ack in the same cycle as expiry takes precedence (no err).
- DONE (one cycle): granted master's rdy=1 and rdata=captured value; the other master's rdy=0. Write transactions return rdata=0. Next state IDLE. Update last-grant pointer.
- Minimum latency: req seen at edge N -> ISSUE in cycle N+1 -> with immediate ack, rdy in cycle N+2. Back-to-back issue earliest at cycle N+4 (one IDLE cycle).
- Non-granted master's rdata reads 0. m*_rdata registered; all s_* outputs registered.
- req dropped mid-transaction: transaction still completes and rdy still pulses; master inputs are ignored after latching.
- s_ack outside ISSUE/WAIT is ignored.
- rst in any state: next cycle IDLE, strobes and rdy deasserted, and any in-flight transaction is abandoned without a rdy pulse.

Test Plan:
- m0 read addr 0x10, s_ack in ISSUE, s_rdata=0x12345678 -> s_rd high 1 cycle, m0_rdy at N+2, m0_rdata=0x12345678, err=0.
- m1 write addr 0x20 data 0xA5, ack after 3 WAIT cycles -> s_wr high only in ISSUE, s_addr/s_wdata stable all 4 cycles, m1_rdy pulse, m0_rdy=0.
- Both req held continuously after reset -> grants alternate m0, m1, m0, m1. gnt tracks, and each rdy pulses once per transaction.
- m0 read, s_ack never asserted, TIMEOUT=15 -> DONE after 15 ISSUE/WAIT cycles, m0_rdata=0xDEADBEEF, err=1 with m0_rdy.
- Ack on the cycle the timeout expires -> real data returned, err=0.
- rst asserted in WAIT -> next cycle IDLE, s_cs=0, no rdy. Both req then -> m0 granted.
